// File: rtl/pulse_meter_pkg.sv
// Shared types and defaults for the pulse width meter.
package pulse_meter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HIGH = 1'b1
  } state_e;

  localparam int unsigned CW_DEFAULT = 8;
  localparam int unsigned NC_DEFAULT = 8;

endpackage

// File: rtl/edge_detect.sv
// Registers a synchronous level and reports its single-cycle rise/fall events.
module edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic sig_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~sig_q;
  assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/pulse_meter.sv
// Measures high-pulse widths of a debounced level and offers each one on a
// single-entry valid/ready slot, with saturation, pulse counting and overrun.
module pulse_meter
  import pulse_meter_pkg::*;
#(
  parameter int unsigned CW = CW_DEFAULT,
  parameter int unsigned NC = NC_DEFAULT
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          sig_in,
  output logic [CW-1:0] width_out,
  output logic          width_sat,
  output logic          width_valid,
  input  logic          width_ready,
  output logic [NC-1:0] pulse_count,
  output logic          overrun
);

  localparam logic [CW-1:0] CntMax = '1;

  logic rise, fall;

  edge_detect u_edge_detect (
    .clk_i  (clock),
    .rst_ni (reset),
    .sig_i  (sig_in),
    .rise_o (rise),
    .fall_o (fall)
  );

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sat_q, sat_d;
  logic [CW-1:0] wout_q, wout_d;
  logic          wsat_q, wsat_d;
  logic          wvalid_q, wvalid_d;
  logic [NC-1:0] pcnt_q, pcnt_d;
  logic          ovr_q, ovr_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sat_d    = sat_q;
    wout_d   = wout_q;
    wsat_d   = wsat_q;
    wvalid_d = wvalid_q;
    pcnt_d   = pcnt_q;
    ovr_d    = ovr_q;

    if (wvalid_q && width_ready) begin
      wvalid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          cnt_d   = CW'(1);
          sat_d   = 1'b0;
          state_d = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (fall) begin
          state_d = ST_IDLE;
          pcnt_d  = pcnt_q + NC'(1);
          // Slot is free if empty or being drained on this same edge.
          if (!wvalid_q || width_ready) begin
            wout_d   = cnt_q;
            wsat_d   = sat_q;
            wvalid_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end else if (sig_in) begin
          if (cnt_q == CntMax) begin
            sat_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      sat_q    <= 1'b0;
      wout_q   <= '0;
      wsat_q   <= 1'b0;
      wvalid_q <= 1'b0;
      pcnt_q   <= '0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sat_q    <= sat_d;
      wout_q   <= wout_d;
      wsat_q   <= wsat_d;
      wvalid_q <= wvalid_d;
      pcnt_q   <= pcnt_d;
      ovr_q    <= ovr_d;
    end
  end

  assign width_out   = wout_q;
  assign width_sat   = wsat_q;
  assign width_valid = wvalid_q;
  assign pulse_count = pcnt_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_pulse_meter.sv
// Directed bench: a default-size meter plus a CW=4/NC=2 meter on shared inputs.
module tb_pulse_meter;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic sig_in = 1'b0;
  logic width_ready = 1'b0;

  logic [7:0] a_out;
  logic       a_sat, a_valid, a_ovr;
  logic [7:0] a_pcnt;
  logic [3:0] b_out;
  logic       b_sat, b_valid, b_ovr;
  logic [1:0] b_pcnt;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  pulse_meter #(.CW(8), .NC(8)) dut_a (
    .clock       (clock),
    .reset       (reset),
    .sig_in      (sig_in),
    .width_out   (a_out),
    .width_sat   (a_sat),
    .width_valid (a_valid),
    .width_ready (width_ready),
    .pulse_count (a_pcnt),
    .overrun     (a_ovr)
  );

  pulse_meter #(.CW(4), .NC(2)) dut_b (
    .clock       (clock),
    .reset       (reset),
    .sig_in      (sig_in),
    .width_out   (b_out),
    .width_sat   (b_sat),
    .width_valid (b_valid),
    .width_ready (width_ready),
    .pulse_count (b_pcnt),
    .overrun     (b_ovr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // n high samples then one low sample; completion is visible on return.
  task automatic pulse(input int n);
    sig_in = 1'b1;
    cyc(n);
    sig_in = 1'b0;
    cyc(1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc(1);
    reset = 1'b1;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_valid", a_valid, 0);
    check("rst_out", a_out, 0);
    check("rst_pcnt", a_pcnt, 0);
    check("rst_ovr", a_ovr, 0);

    // Basic 5-cycle pulse
    width_ready = 1'b1;
    pulse(5);
    check("p5_valid", a_valid, 1);
    check("p5_out", a_out, 5);
    check("p5_sat", a_sat, 0);
    check("p5_pcnt", a_pcnt, 1);
    cyc(1);
    check("p5_valid_drop", a_valid, 0);
    check("p5_out_hold", a_out, 5);

    // Minimum pulse, then back-to-back 3 / 2 with a single low gap
    pulse(1);
    check("p1_out", a_out, 1);
    check("p1_valid", a_valid, 1);
    pulse(3);
    check("p3_out", a_out, 3);
    pulse(2);
    check("p2_out", a_out, 2);
    check("p2_valid", a_valid, 1);
    check("p2_pcnt", a_pcnt, 4);

    // Saturation on the CW=4 instance
    do_reset();
    pulse(20);
    check("sat_b_out", b_out, 15);
    check("sat_b_sat", b_sat, 1);
    check("sat_a_out", a_out, 20);
    check("sat_a_sat", a_sat, 0);
    pulse(3);
    check("unsat_b_out", b_out, 3);
    check("unsat_b_sat", b_sat, 0);
    pulse(15);
    check("edge15_b_out", b_out, 15);
    check("edge15_b_sat", b_sat, 0);

    // Back-pressure: second measurement dropped
    do_reset();
    width_ready = 1'b0;
    pulse(4);
    check("bp_valid", a_valid, 1);
    check("bp_out4", a_out, 4);
    check("bp_ovr0", a_ovr, 0);
    pulse(6);
    check("bp_out_held", a_out, 4);
    check("bp_ovr", a_ovr, 1);
    check("bp_pcnt", a_pcnt, 2);
    check("bp_valid_held", a_valid, 1);
    cyc(3);
    check("bp_out_stable", a_out, 4);
    width_ready = 1'b1;
    cyc(1);
    check("bp_xfer_valid", a_valid, 0);
    check("bp_xfer_out", a_out, 4);
    check("bp_ovr_sticky", a_ovr, 1);

    // Simultaneous transfer and completion
    do_reset();
    width_ready = 1'b0;
    pulse(3);
    check("sim_first", a_out, 3);
    sig_in = 1'b1;
    cyc(7);
    width_ready = 1'b1;
    sig_in = 1'b0;
    cyc(1);
    check("sim_out", a_out, 7);
    check("sim_valid", a_valid, 1);
    check("sim_ovr", a_ovr, 0);
    check("sim_pcnt", a_pcnt, 2);
    cyc(1);
    check("sim_drain", a_valid, 0);

    // Reset mid-pulse
    sig_in = 1'b1;
    cyc(3);
    reset = 1'b0;
    #1;
    check("mid_out", a_out, 0);
    check("mid_valid", a_valid, 0);
    check("mid_pcnt", a_pcnt, 0);
    sig_in = 1'b0;
    cyc(1);
    reset = 1'b1;
    cyc(3);
    check("mid_after_valid", a_valid, 0);
    check("mid_after_pcnt", a_pcnt, 0);

    // Release reset with sig_in already high
    reset = 1'b0;
    sig_in = 1'b1;
    cyc(1);
    reset = 1'b1;
    cyc(4);
    sig_in = 1'b0;
    cyc(1);
    check("hi_rel_out", a_out, 4);
    check("hi_rel_valid", a_valid, 1);

    // Pulse counter wrap with NC=2
    do_reset();
    for (int i = 0; i < 5; i++) begin
      pulse(2);
    end
    check("wrap_b_pcnt", b_pcnt, 1);
    check("wrap_a_pcnt", a_pcnt, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/pulse_meter.md
# pulse_meter

Measures the high-pulse width of the debounced level produced by the upstream glitch filter and hands each measurement to the consumer over a valid/ready interface. Sits directly downstream of the filter's `sig_out` and counts clock cycles while the level is high. Reports saturation for over-long pulses, counts completed pulses, and flags measurements dropped under back-pressure.

## Interface
- `CW`, 8: width-counter and `width_out` width; maximum reportable width is 2^CW-1.
- `NC`, 8: completed-pulse counter width.

- `clock`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `sig_in`  in  1  debounced level from the filter stage; synchronous to `clock`.
- `width_out`  out  CW  measured high width in clock cycles.
- `width_sat`  out  1  measurement saturated; qualifies `width_out`.
- `width_valid`  out  1  measurement available.
- `width_ready`  in  1  consumer accepts; transfer when `width_valid & width_ready`.
- `pulse_count`  out  NC  completed pulses since reset, wraps modulo 2^NC.
- `overrun`  out  1  sticky; a completed measurement was dropped.

## Operation
- Edge detection: register `sig_d <= sig_in` (reset 0).
  - `rise = sig_in & ~sig_d`.
  - `fall = ~sig_in & sig_d`.
  - Rise and fall are mutually exclusive.
- FSM, two states:
  - IDLE (reset state): on `rise`, set `cnt <= 1`, clear `sat_f`, go to HIGH.
  - HIGH, `sig_in` = 1: `cnt <= cnt + 1`. At 2^CW-1, `cnt` holds and `sat_f <= 1`.
  - HIGH, `fall`: complete the measurement and return to IDLE.
- Width definition: number of rising clock edges at which `sig_in` sampled 1.
- Completion, slot free (`width_valid` = 0, or transfer in the same cycle):
  - Load `width_out <= cnt` and `width_sat <= sat_f`.
  - Set `width_valid <= 1`.
- Completion, slot held (`width_valid & ~width_ready`):
  - Discard the measurement; slot contents are unchanged.
  - Set `overrun <= 1`; it clears only on reset.
- `pulse_count` increments on every completion, dropped or not. Wraps from 2^NC-1 to 0.
- Transfer with no completion in the same cycle: `width_valid <= 0`. `width_out` and `width_sat` hold their values.
- While `width_valid & ~width_ready`: `width_out` and `width_sat` are stable.
- Reset mid-pulse: measurement abandoned, nothing reported.
- After reset release with `sig_in` already 1: the next edge sees `rise`, and the pulse is measured normally.

## Timing
- Reset values: `width_out` = 0, `width_sat` = 0, `width_valid` = 0, `pulse_count` = 0, `overrun` = 0, FSM = IDLE, `sig_d` = 0.
- Latency:
  - `width_valid` rises at the edge that samples the fall, i.e. one edge after `sig_in` drops.
  - `pulse_count` updates at the same edge.
- Minimum pulse: 1 high sample gives width 1.
- Minimum gap: 1 low sample. The next rise may be sampled on the edge immediately after the fall edge, so back-to-back measurements are possible every 2 cycles.
- Simultaneous transfer and completion: the new value loads and `width_valid` stays 1. No overrun.
- `width_ready` is ignored while `width_valid` = 0.
- No combinational path from `width_ready` to any output.

## Structure
- Shared package `pulse_meter_pkg`:
  - State encodings `ST_IDLE` = 1'b0, `ST_HIGH` = 1'b1.
  - Default `CW`/`NC` constants.
- One sub-module, `edge_detect`: owns `sig_d` and produces `rise`/`fall`. It is reusable by other consumers of the filter output.
- Top level holds the FSM, the saturating counter, the output slot and the pulse counter.

## Test plan
- Reset, then `sig_in` high for 5 cycles, then low, `width_ready` = 1 -> `width_valid` pulses for 1 cycle with `width_out` = 5, `width_sat` = 0, `pulse_count` = 1.
- 1-cycle high pulse -> `width_out` = 1. Pulses high 3, low 1, high 2 -> two transfers: 3 then 2.
- `CW` = 4, pulse high 20 cycles -> `width_out` = 15, `width_sat` = 1. Next 3-cycle pulse -> `width_sat` = 0.
- `width_ready` = 0, pulses of 4 then 6 ->
  - `width_out` stays 4, `overrun` = 1, `pulse_count` = 2.
  - Raise `width_ready` -> single transfer of 4.
- Valid held, then `width_ready` asserted on the same edge a 7-cycle pulse completes -> old value transferred, `width_out` = 7, `width_valid` stays 1, `overrun` = 0.
- Assert `reset` mid-pulse, then release with `sig_in` = 0 -> all outputs 0, no measurement reported.
- With `NC` = 2, 5 pulses -> `pulse_count` = 1.
